// File: rtl/pos_cell_reader.sv
// Purpose : streams one particle cell (count word 0, then words 1..count) from a cell memory.
// Latency : start to first out_valid is 7 cycles; one word per cycle while out_ready is held high.
// Backpress: out_ready low stalls the output with data held stable; reads stop while in-flight + queued reaches 4.
//
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   start / busy / done  : one-cycle request, in-progress flag, one-cycle completion pulse
//   mem_address, mem_rden, mem_wren, mem_q : cell memory port (read data arrives 2 cycles after issue)
//   particle_count       : count word latched for the current cell
//   out_valid/out_ready/out_data/out_index/out_last : particle stream, out_index = word address
//   count_err            : sticky flag for a clamped count
//
// Build option: define POS_CELL_READER_COUNT_CLAMP_EN to clamp counts above PARTICLE_NUM-1 and
// raise count_err; without it the count is used as read and count_err stays 0.
module pos_cell_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  count_err
);

    // The cell memory cannot hold more words than the address space reaches.
    if (PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("pos_cell_reader: PARTICLE_NUM exceeds the address space");
    end

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

    state_t                state, state_nxt;
    logic                  wait_2nd;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  issue;

    // Two-deep shadow of the memory read pipeline: a read issued in cycle t returns in t+2.
    logic [1:0]            pipe_vld;
    logic [ADDR_WIDTH-1:0] pipe_idx [2];

    logic [DATA_WIDTH-1:0] fifo_dat [4];
    logic [ADDR_WIDTH-1:0] fifo_idx [4];
    logic [1:0]            fifo_wp, fifo_rp;
    logic [2:0]            fifo_cnt;
    logic                  push, pop;
    logic [2:0]            in_flight;
    logic                  room;

    logic [ADDR_WIDTH-1:0] cnt_eff;

`ifdef POS_CELL_READER_COUNT_CLAMP_EN
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
    logic cnt_over;
    assign cnt_over = (mem_q[ADDR_WIDTH-1:0] > CNT_MAX);
    assign cnt_eff  = cnt_over ? CNT_MAX : mem_q[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_err <= 1'b0;
        end else if (state == WAIT_CNT && wait_2nd && cnt_over) begin
            count_err <= 1'b1;
        end
    end
`else
    assign cnt_eff   = mem_q[ADDR_WIDTH-1:0];
    assign count_err = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign mem_wren  = 1'b0;

    // Reads are admitted only while every word already requested still has a FIFO slot.
    assign in_flight = {2'b00, pipe_vld[0]} + {2'b00, pipe_vld[1]};
    assign room      = ((in_flight + fifo_cnt) < 3'd4);

    assign push      = pipe_vld[1];
    assign out_valid = (fifo_cnt != 3'd0);
    assign out_data  = fifo_dat[fifo_rp];
    assign out_index = fifo_idx[fifo_rp];
    assign out_last  = out_valid && (out_index == particle_count);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt   = state;
        mem_rden    = 1'b0;
        mem_address = addr_hold;
        issue       = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = RD_CNT;
            RD_CNT: begin
                mem_rden    = 1'b1;
                mem_address = '0;
                state_nxt   = WAIT_CNT;
            end
            WAIT_CNT: if (wait_2nd) state_nxt = (cnt_eff == '0) ? FIN : STREAM;
            STREAM: begin
                if (room) begin
                    mem_rden    = 1'b1;
                    mem_address = rd_ptr;
                    issue       = 1'b1;
                    if (rd_ptr == particle_count) state_nxt = DRAIN;
                end
            end
            DRAIN:    if (pop && out_last) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_2nd       <= 1'b0;
            rd_ptr         <= '0;
            addr_hold      <= '0;
            particle_count <= '0;
            pipe_vld       <= 2'b00;
            pipe_idx[0]    <= '0;
            pipe_idx[1]    <= '0;
        end else begin
            state       <= state_nxt;
            addr_hold   <= mem_address;
            wait_2nd    <= (state == WAIT_CNT) && !wait_2nd;
            pipe_vld    <= {pipe_vld[0], issue};
            pipe_idx[0] <= rd_ptr;
            pipe_idx[1] <= pipe_idx[0];
            if (state == WAIT_CNT && wait_2nd) begin
                particle_count <= cnt_eff;
                rd_ptr         <= ADDR_WIDTH'(1);
            end else if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the idle output bus reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wp  <= 2'd0;
            fifo_rp  <= 2'd0;
            fifo_cnt <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_dat[i] <= '0;
                fifo_idx[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_dat[fifo_wp] <= mem_q;
                fifo_idx[fifo_wp] <= pipe_idx[1];
                fifo_wp           <= fifo_wp + 2'd1;
            end
            if (pop) fifo_rp <= fifo_rp + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_pos_cell_reader.sv
module tb_pos_cell_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done, mem_rden, mem_wren;
    logic          out_valid, out_ready, out_last, count_err;
    logic [AW-1:0] mem_address, particle_count, out_index;
    logic [DW-1:0] mem_q, out_data;

    logic [DW-1:0] mem_arr [256];
    logic [AW-1:0] mem_a1;
    int            vectors = 0;
    int            errors  = 0;
    bit            err_flag = 1'b0;

    pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .particle_count(particle_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last), .count_err(count_err)
    );

    always #5 clk = ~clk;

    // Cell memory: address registered on the issue edge, data registered one edge later.
    always @(posedge clk) begin
        if (mem_rden) mem_a1 <= mem_address;
        mem_q <= mem_arr[mem_a1];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_cnt(input int w);
`ifdef POS_CELL_READER_COUNT_CLAMP_EN
        return (w > PN - 1) ? PN - 1 : w;
`else
        return w % 256;
`endif
    endfunction

    function automatic bit clamps(input int w);
`ifdef POS_CELL_READER_COUNT_CLAMP_EN
        return w > PN - 1;
`else
        return (w < 0);
`endif
    endfunction

    task automatic fill(input int cnt_word);
        mem_arr[0] = DW'(cnt_word);
        for (int i = 1; i < 256; i++) mem_arr[i] = {$urandom, $urandom, $urandom};
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rden"}, mem_rden, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_err"}, count_err, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_pcount"}, particle_count, 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_data"}, out_data, 0);
    endtask

    // mode 0: out_ready=1 with exact timing checks; 1: ready pattern 1,0,0; 2: random ready.
    task automatic run_cell(input int cnt_word, input int mode, input bit restart5);
        int n, k, done_cyc, done_at, done_cnt, issued, xfers, budget;
        bit stall, rdy;
        logic [DW-1:0] pd;
        logic [AW-1:0] pi;
        logic pl;
        n = eff_cnt(cnt_word);
        if (clamps(cnt_word)) err_flag = 1'b1;
        done_cyc = (n == 0) ? 4 : 7 + n;
        budget = 6 * n + 40;
        k = 0; done_at = 0; done_cnt = 0; issued = 0; xfers = 0; stall = 1'b0;
        pd = '0; pi = '0; pl = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = (restart5 && cyc == 5);
            if (mem_rden && mem_address != 0) issued++;
            chk("mem_wren", mem_wren, 0);
            chk("inflight_bound", ((issued - xfers) <= 4), 1);
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_index", out_index, pi);
                chk("stall_last", out_last, pl);
            end
            if (mode == 0) begin
                chk("out_valid", out_valid, (cyc >= 7 && cyc < 7 + n));
                chk("done", done, (cyc == done_cyc));
                chk("busy", busy, (cyc <= done_cyc));
                chk("mem_rden", mem_rden, (cyc == 1 || (cyc >= 4 && cyc < 4 + n)));
                if (mem_rden) chk("mem_address", mem_address, (cyc == 1) ? 0 : cyc - 3);
            end
            if (out_valid) chk("last_flag", out_last, (int'(out_index) == n));
            if (out_valid && out_ready) begin
                chk("word_data", out_data, mem_arr[(k + 1) % 256]);
                chk("word_index", out_index, k + 1);
                k++; xfers++;
            end
            stall = out_valid && !out_ready;
            pd = out_data; pi = out_index; pl = out_last;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
                chk("words_at_done", k, n);
                chk("pcount", particle_count, n);
                chk("count_err", count_err, err_flag);
            end
            if (done_at > 0 && cyc == done_at + 1) begin
                chk("idle_busy", busy, 0);
                chk("idle_valid", out_valid, 0);
            end
            if (done_at > 0 && cyc >= done_at + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_once", done_cnt, 1);
        chk("words_total", k, n);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; mem_a1 = '0;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three-word cell, exact timing.
        fill(3);
        run_cell(3, 0, 1'b0);
        // Empty cell: done at T+4.
        fill(0);
        run_cell(0, 0, 1'b0);
        // Second start during a stream is ignored.
        fill(3);
        run_cell(3, 0, 1'b1);
        // Single word, then stalled patterns.
        fill(1);
        run_cell(1, 0, 1'b0);
        fill(10);
        run_cell(10, 1, 1'b0);
        fill(7);
        run_cell(7, 2, 1'b0);
        fill(40);
        run_cell(40, 2, 1'b0);

        // Reset in the middle of a 10-word stream.
        fill(10);
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        err_flag = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_reset_quiet", (out_valid | busy | mem_rden), 0);
        end
        fill(5);
        run_cell(5, 0, 1'b0);

        // Oversized count word, then a small cell to observe the sticky flag.
        fill(250);
        run_cell(250, 2, 1'b0);
        fill(2);
        run_cell(2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
